servant_wb_arbiter: RTL and testbench
=====================================

// Module: servant_wb_arbiter
// PURPOSE
//  Shares the single servant RAM Wishbone slave port between NM masters: CPU ibus, CPU dbus, external loader.
//  Round-robin, one transaction in flight, grant held until slave ack.
//  Sits between the CPU/loader buses and servant RAM in the wb_clk domain.
// PARAMETERS
//  NM      3    number of masters (2..4); index 0 = ibus, 1 = dbus, 2 = loader
//  AW      32   address width
//  DW      32   data width; sel width = DW/8
//  TMO     255  timeout in cycles, 1..255 (used only with SERVANT_ARB_TIMEOUT_EN)
// PORTS
//  wb_clk     in   1        clock
//  wb_rst     in   1        async reset, active-high
//  i_m_adr    in   NM*AW    master addresses, master k at [k*AW +: AW]
//  i_m_dat    in   NM*DW    master write data
//  i_m_sel    in   NM*DW/8  master byte selects
//  i_m_we     in   NM       master write enables
//  i_m_cyc    in   NM       master requests; held high until ack
//  o_m_rdt    out  DW       read data, shared by all masters
//  o_m_ack    out  NM       per-master ack, one-cycle pulse
//  o_s_adr    out  AW       slave address
//  o_s_dat    out  DW       slave write data
//  o_s_sel    out  DW/8     slave byte selects
//  o_s_we     out  1        slave write enable
//  o_s_cyc    out  1        slave request
//  i_s_rdt    in   DW       slave read data
//  i_s_ack    in   1        slave ack
//  o_grant    out  NM       one-hot registered grant, 0 when idle
//  o_timeout  out  1        one-cycle pulse when a transaction is killed by timeout
// BEHAVIOUR
//  Reset: state IDLE, o_grant=0, o_s_cyc=0, o_m_ack=0, o_timeout=0, rr pointer=0 (master 0 highest priority).
//  IDLE: if any i_m_cyc, pick the first requester at or after the pointer (wrapping), register grant -> BUSY.
//    Latency: request in cycle N, o_s_cyc=1 in cycle N+1.
//  BUSY: o_s_* = fields of the granted master (combinational mux); o_s_cyc = i_m_cyc[g].
//    o_m_ack[g] = i_s_ack & i_m_cyc[g]; o_m_rdt = i_s_rdt, passed through unregistered.
//  BUSY -> IDLE on i_s_ack: grant clears next cycle; pointer = g+1 mod NM.
//    One idle bubble cycle between back-to-back grants.
//  Abort: granted master drops cyc before ack -> o_s_cyc falls the same cycle.
//    No ack is forwarded; next cycle -> IDLE and pointer advances.
//  Ack in the same cycle the master drops cyc: ignored, handled as abort.
//  i_s_ack while IDLE: ignored, no o_m_ack.
//  Reset asserted mid-transaction: all outputs return to reset values immediately; in-flight transaction is lost.
//  Non-granted masters never see ack; their cyc is simply held pending.
// CONFIGURATION
//  SERVANT_ARB_TIMEOUT_EN defined:
//    8-bit counter runs in BUSY and reloads 0 on each grant.
//    At count==TMO: o_m_ack[g]=1, o_m_rdt=32'hDEAD_BEEF, o_timeout=1 for one cycle, o_s_cyc=0 that cycle -> IDLE, pointer advances.
//  SERVANT_ARB_TIMEOUT_EN undefined: no counter; o_timeout tied 0; a hung slave stalls the arbiter indefinitely.
// STRUCTURE
//  Package servant_wb_arbiter_pkg: state enum {IDLE,BUSY}, TMO_RDATA=32'hDEAD_BEEF, counter width constant.
//  Sub-module servant_wb_rr_picker: combinational rotating priority encoder (req[NM], ptr) -> one-hot grant, valid.
//  Top holds the FSM, pointer, timeout counter and output muxes.
// TESTING
//  1. Single ibus read, slave acks 1 cycle after cyc, rdt=0x1234_5678
//     -> o_s_cyc at N+1, o_m_ack[0] pulse, o_m_rdt=0x1234_5678.
//  2. All 3 cyc high constantly, slave acks every cycle
//     -> grants rotate 0,1,2,0 with one idle cycle between; no master starved.
//  3. dbus write adr=0x100 dat=0xA5A5_A5A5 sel=4'b0011
//     -> o_s_adr/dat/sel/we match exactly; only o_m_ack[1] pulses.
//  4. Loader granted, drops cyc 2 cycles later with no ack
//     -> o_s_cyc falls the same cycle, no o_m_ack, IDLE next cycle, pointer=0.
//  5. Reset pulse while BUSY
//     -> o_grant=0, o_s_cyc=0 asynchronously; after release ibus wins first.
//  6. (SERVANT_ARB_TIMEOUT_EN, TMO=4) slave never acks
//     -> 4 cycles after grant: o_timeout=1, o_m_ack[g]=1, rdt=0xDEAD_BEEF.

Source files
------------

// File: rtl/servant_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : servant_wb_arbiter_pkg
//  Brief    : Shared types and constants for the servant RAM Wishbone arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package servant_wb_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Read data returned to a master whose transaction was killed by timeout
    localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

    localparam int CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/servant_wb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : servant_wb_rr_picker
//  Brief    : Rotating priority encoder; first requester at or after i_ptr wins.
//  Revision : 1.0 - initial release
// ============================================================================
module servant_wb_rr_picker
    import servant_wb_arbiter_pkg::*;
#(
    parameter int NM = 3,
    parameter int PW = 2
) (
    input  logic [NM-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NM-1:0] o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_k;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_sum   = '0;
        w_k     = '0;
        for (int i = 0; i < NM; i++) begin
            // Candidate index (ptr + i) mod NM without a divider
            w_sum = {1'b0, i_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NM)) begin
                w_sum = w_sum - (PW+1)'(NM);
            end
            w_k = w_sum[PW-1:0];
            if (!o_valid && i_req[w_k]) begin
                o_grant[w_k] = 1'b1;
                o_idx        = w_k;
                o_valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/servant_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : servant_wb_arbiter
//  Brief    : Round-robin arbiter sharing the servant RAM Wishbone slave port.
//             Optional slave timeout enabled by defining SERVANT_ARB_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module servant_wb_arbiter
    import servant_wb_arbiter_pkg::*;
#(
    parameter int NM  = 3,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    input  logic [NM*AW-1:0]   i_m_adr,
    input  logic [NM*DW-1:0]   i_m_dat,
    input  logic [NM*DW/8-1:0] i_m_sel,
    input  logic [NM-1:0]      i_m_we,
    input  logic [NM-1:0]      i_m_cyc,
    output logic [DW-1:0]      o_m_rdt,
    output logic [NM-1:0]      o_m_ack,
    output logic [AW-1:0]      o_s_adr,
    output logic [DW-1:0]      o_s_dat,
    output logic [DW/8-1:0]    o_s_sel,
    output logic               o_s_we,
    output logic               o_s_cyc,
    input  logic [DW-1:0]      i_s_rdt,
    input  logic               i_s_ack,
    output logic [NM-1:0]      o_grant,
    output logic               o_timeout
);

    localparam int PW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;

    arb_state_e    r_state;
    arb_state_e    w_next_state;
    logic [NM-1:0] r_grant;
    logic [PW-1:0] r_gidx;
    logic [PW-1:0] r_ptr;

    logic [NM-1:0] w_pick_grant;
    logic [PW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic          w_g_cyc;
    logic          w_tmo_hit;
    logic          w_done;

    servant_wb_rr_picker #(
        .NM (NM),
        .PW (PW)
    ) u_picker (
        .i_req   (i_m_cyc),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // r_grant is zero outside BUSY, so this also reads as "granted master still requesting"
    assign w_g_cyc = |(r_grant & i_m_cyc);

    // A dropped cyc ends the transaction even if ack arrives in the same cycle
    assign w_done  = (r_state == BUSY) && (!w_g_cyc || i_s_ack || w_tmo_hit);

`ifdef SERVANT_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] c_tmo = CNT_W'(TMO);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // A real ack or an abort in the expiry cycle takes precedence over the timeout
    assign w_tmo_hit = (r_state == BUSY) && (r_cnt == c_tmo) && w_g_cyc && !i_s_ack;
`else
    assign w_tmo_hit = 1'b0;
`endif

    // TMO is only meaningful in 1..255; nothing is built from it here
    if ((TMO < 1) || (TMO > 255)) begin : g_tmo_out_of_range
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_pick_valid) begin
                r_grant <= w_pick_grant;
                r_gidx  <= w_pick_idx;
            end else if (w_done) begin
                r_grant <= '0;
                r_ptr   <= (r_gidx == PW'(NM-1)) ? '0 : r_gidx + PW'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_next_state = BUSY;
            BUSY:    if (w_done)       w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        for (int k = 0; k < NM; k++) begin
            if (r_grant[k]) begin
                o_s_adr = i_m_adr[k*AW +: AW];
                o_s_dat = i_m_dat[k*DW +: DW];
                o_s_sel = i_m_sel[k*SW +: SW];
                o_s_we  = i_m_we[k];
            end
        end
        o_s_cyc   = w_g_cyc && !w_tmo_hit;
        o_m_ack   = (r_grant & i_m_cyc & {NM{i_s_ack}}) | (r_grant & {NM{w_tmo_hit}});
        o_m_rdt   = w_tmo_hit ? DW'(TMO_RDATA) : i_s_rdt;
        o_timeout = w_tmo_hit;
    end

    assign o_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_servant_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servant_wb_arbiter
//  Brief    : Self-checking bench: vector table, directed corners, random vs model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_servant_wb_arbiter;

    localparam int NM  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic               wb_clk = 1'b0;
    logic               wb_rst = 1'b1;
    logic [NM*AW-1:0]   i_m_adr;
    logic [NM*DW-1:0]   i_m_dat;
    logic [NM*SW-1:0]   i_m_sel;
    logic [NM-1:0]      i_m_we;
    logic [NM-1:0]      i_m_cyc;
    logic [DW-1:0]      o_m_rdt;
    logic [NM-1:0]      o_m_ack;
    logic [AW-1:0]      o_s_adr;
    logic [DW-1:0]      o_s_dat;
    logic [SW-1:0]      o_s_sel;
    logic               o_s_we;
    logic               o_s_cyc;
    logic [DW-1:0]      i_s_rdt;
    logic               i_s_ack;
    logic [NM-1:0]      o_grant;
    logic               o_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [NM-1:0] cyc;
        logic          s_ack;
        logic [NM-1:0] grant;
        logic          s_cyc;
        logic [NM-1:0] ack;
    } vec_t;

    vec_t tbl [18];

    servant_wb_arbiter #(
        .NM  (NM),
        .AW  (AW),
        .DW  (DW),
        .TMO (TMO)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .i_m_adr   (i_m_adr),
        .i_m_dat   (i_m_dat),
        .i_m_sel   (i_m_sel),
        .i_m_we    (i_m_we),
        .i_m_cyc   (i_m_cyc),
        .o_m_rdt   (o_m_rdt),
        .o_m_ack   (o_m_ack),
        .o_s_adr   (o_s_adr),
        .o_s_dat   (o_s_dat),
        .o_s_sel   (o_s_sel),
        .o_s_we    (o_s_we),
        .o_s_cyc   (o_s_cyc),
        .i_s_rdt   (i_s_rdt),
        .i_s_ack   (i_s_ack),
        .o_grant   (o_grant),
        .o_timeout (o_timeout)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel);
        i_m_cyc[k]            = cyc;
        i_m_we[k]             = we;
        i_m_adr[k*AW +: AW]   = adr;
        i_m_dat[k*DW +: DW]   = dat;
        i_m_sel[k*SW +: SW]   = sel;
    endtask

    task automatic clear_inputs();
        i_m_adr = '0;
        i_m_dat = '0;
        i_m_sel = '0;
        i_m_we  = '0;
        i_m_cyc = '0;
        i_s_rdt = '0;
        i_s_ack = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        wb_rst = 1'b1;
        repeat (2) @(posedge wb_clk);
        #1;
        wb_rst = 1'b0;
    endtask

    // Behavioural reference: integer grant index, round-robin pointer, timeout age
    task automatic run_random(input int ncyc);
        bit            busy;
        bit            gcyc;
        bit            tmo;
        bit            on;
        int            g;
        int            ptr;
        int            cnt;
        int            k;
        logic [NM-1:0] exp_grant;
        logic [NM-1:0] exp_ack;
        busy = 0; g = 0; ptr = 0; cnt = 0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            for (int m = 0; m < NM; m++) begin
                on = i_m_cyc[m] ? ($urandom_range(9) != 0) : ($urandom_range(2) == 0);
                set_m(m, on, 1'($urandom_range(1)), $urandom, $urandom, SW'($urandom_range(15)));
            end
            i_s_ack = ($urandom_range(2) == 0);
            i_s_rdt = $urandom;
            #2;
            exp_grant = '0;
            exp_ack   = '0;
            gcyc      = 0;
            tmo       = 0;
            if (busy) begin
                exp_grant[g] = 1'b1;
                gcyc         = i_m_cyc[g];
            end
`ifdef SERVANT_ARB_TIMEOUT_EN
            if (gcyc && cnt == TMO && !i_s_ack) tmo = 1;
`endif
            if (gcyc && (i_s_ack || tmo)) exp_ack[g] = 1'b1;
            chk("rnd_grant",   o_grant,   exp_grant);
            chk("rnd_s_cyc",   o_s_cyc,   gcyc && !tmo);
            chk("rnd_ack",     o_m_ack,   exp_ack);
            chk("rnd_rdt",     o_m_rdt,   tmo ? 32'hDEAD_BEEF : i_s_rdt);
            chk("rnd_timeout", o_timeout, tmo);
            if (busy) begin
                chk("rnd_s_adr", o_s_adr, i_m_adr[g*AW +: AW]);
                chk("rnd_s_dat", o_s_dat, i_m_dat[g*DW +: DW]);
                chk("rnd_s_sel", o_s_sel, i_m_sel[g*SW +: SW]);
                chk("rnd_s_we",  o_s_we,  i_m_we[g]);
            end
            if (!busy) begin
                for (int i = 0; i < NM; i++) begin
                    k = (ptr + i) % NM;
                    if (!busy && i_m_cyc[k]) begin
                        busy = 1; g = k; cnt = 0;
                    end
                end
            end else if (!gcyc || i_s_ack || tmo) begin
                busy = 0;
                ptr  = (g + 1) % NM;
            end else begin
                cnt++;
            end
        end
    endtask

    initial begin
        clear_inputs();
        // cyc, s_ack -> grant, s_cyc, ack: rotation, loader abort with late ack, idle ack
        tbl[0]  = '{3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
        tbl[1]  = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001};
        tbl[2]  = '{3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
        tbl[3]  = '{3'b111, 1'b1, 3'b010, 1'b1, 3'b010};
        tbl[4]  = '{3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
        tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1, 3'b100};
        tbl[6]  = '{3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
        tbl[7]  = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001};
        tbl[8]  = '{3'b100, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[9]  = '{3'b100, 1'b0, 3'b100, 1'b1, 3'b000};
        tbl[10] = '{3'b100, 1'b0, 3'b100, 1'b1, 3'b000};
        tbl[11] = '{3'b000, 1'b1, 3'b100, 1'b0, 3'b000};
        tbl[12] = '{3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[13] = '{3'b111, 1'b0, 3'b001, 1'b1, 3'b000};
        tbl[14] = '{3'b111, 1'b1, 3'b001, 1'b1, 3'b001};
        tbl[15] = '{3'b000, 1'b1, 3'b000, 1'b0, 3'b000};
        tbl[16] = '{3'b010, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[17] = '{3'b010, 1'b0, 3'b010, 1'b1, 3'b000};

        repeat (2) @(posedge wb_clk);
        #1;
        chk("reset_grant",   o_grant,   3'b000);
        chk("reset_s_cyc",   o_s_cyc,   1'b0);
        chk("reset_ack",     o_m_ack,   3'b000);
        chk("reset_timeout", o_timeout, 1'b0);
        wb_rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            tick();
            i_m_cyc = tbl[i].cyc;
            i_s_ack = tbl[i].s_ack;
            #2;
            chk($sformatf("tbl%0d_grant", i), o_grant, tbl[i].grant);
            chk($sformatf("tbl%0d_s_cyc", i), o_s_cyc, tbl[i].s_cyc);
            chk($sformatf("tbl%0d_ack", i),   o_m_ack, tbl[i].ack);
        end

        // Single ibus read
        do_reset();
        tick();
        set_m(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        #2;
        chk("rd_s_cyc_n", o_s_cyc, 1'b0);
        tick();
        i_s_ack = 1'b1;
        i_s_rdt = 32'h1234_5678;
        #2;
        chk("rd_s_cyc_n1", o_s_cyc, 1'b1);
        chk("rd_grant",    o_grant, 3'b001);
        chk("rd_s_adr",    o_s_adr, 32'h0000_0040);
        chk("rd_ack",      o_m_ack, 3'b001);
        chk("rd_rdt",      o_m_rdt, 32'h1234_5678);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        i_s_ack = 1'b0;
        #2;
        chk("rd_grant_clear", o_grant, 3'b000);

        // dbus write with distinct idle-master fields
        do_reset();
        tick();
        set_m(0, 1'b0, 1'b0, 32'h5555_0000, 32'h1111_1111, 4'hF);
        set_m(1, 1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'b0011);
        set_m(2, 1'b0, 1'b1, 32'h0000_0FFF, 32'h2222_2222, 4'hC);
        #2;
        tick();
        i_s_ack = 1'b1;
        #2;
        chk("wr_grant", o_grant, 3'b010);
        chk("wr_s_adr", o_s_adr, 32'h0000_0100);
        chk("wr_s_dat", o_s_dat, 32'hA5A5_A5A5);
        chk("wr_s_sel", o_s_sel, 4'b0011);
        chk("wr_s_we",  o_s_we,  1'b1);
        chk("wr_ack",   o_m_ack, 3'b010);
        tick();
        clear_inputs();
        #2;
        chk("wr_ack_clear", o_m_ack, 3'b000);

        // Asynchronous reset while BUSY
        do_reset();
        tick();
        i_m_cyc = 3'b111;
        #2;
        tick();
        #2;
        chk("rst_busy_s_cyc", o_s_cyc, 1'b1);
        i_s_ack = 1'b1;
        #1;
        wb_rst = 1'b1;
        #1;
        chk("rst_async_grant", o_grant, 3'b000);
        chk("rst_async_s_cyc", o_s_cyc, 1'b0);
        chk("rst_async_ack",   o_m_ack, 3'b000);
        @(posedge wb_clk);
        #1;
        wb_rst  = 1'b0;
        i_s_ack = 1'b0;
        #2;
        chk("rst_rel_idle", o_grant, 3'b000);
        tick();
        #2;
        chk("rst_rel_first", o_grant, 3'b001);
        tick();
        clear_inputs();

        // Hung slave
        do_reset();
        tick();
        set_m(2, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        i_s_rdt = 32'h0BAD_0BAD;
        #2;
        tick();
        #2;
        chk("hang_grant", o_grant, 3'b100);
`ifdef SERVANT_ARB_TIMEOUT_EN
        for (int c = 1; c < TMO; c++) begin
            tick();
            #2;
            chk($sformatf("tmo_wait%0d_s_cyc", c),   o_s_cyc,   1'b1);
            chk($sformatf("tmo_wait%0d_timeout", c), o_timeout, 1'b0);
        end
        tick();
        #2;
        chk("tmo_timeout", o_timeout, 1'b1);
        chk("tmo_ack",     o_m_ack,   3'b100);
        chk("tmo_rdt",     o_m_rdt,   32'hDEAD_BEEF);
        chk("tmo_s_cyc",   o_s_cyc,   1'b0);
        tick();
        #2;
        chk("tmo_idle", o_grant, 3'b000);
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            #2;
            chk($sformatf("hang%0d_s_cyc", c),   o_s_cyc,   1'b1);
            chk($sformatf("hang%0d_timeout", c), o_timeout, 1'b0);
            chk($sformatf("hang%0d_grant", c),   o_grant,   3'b100);
        end
        tick();
        i_s_ack = 1'b1;
        #2;
        chk("hang_late_ack", o_m_ack, 3'b100);
        tick();
        clear_inputs();
        #2;
        chk("hang_idle", o_grant, 3'b000);
`endif

        do_reset();
        run_random(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
